prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Top-level fetch controller that drives the program counter's Reset, BranchAbs and Target inputs. It launches one of three stored programs on a Start handshake and passes decoder branch requests through while running. It holds the PC on halt and reports Done to the testbench. It sits between the testbench/top level, the instruction decoder, and the program counter register.

Parameters:
L, 10, PC/target width in bits
BASE0, 0, start address of program 1 (ProgSel=0)
BASE1, 256, start address of program 2 (ProgSel=1)
BASE2, 512, start address of program 3 (ProgSel=2)
CW, 16, cycle counter width
WDT_LIMIT, 4096, watchdog limit in RUN cycles (used only with WATCHDOG_EN)

Ports:
Clk  in  1  system clock; all state changes on the posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  level from testbench; rising edge launches a program
ProgSel  in  2  program select, sampled with the Start edge; 3 = invalid
CurPC  in  L  current program counter value
HaltReq  in  1  decoder: the current instruction is halt
BranchReq  in  1  decoder: take branch this cycle
BranchTarget  in  L  decoder: absolute branch target
PcReset  out  1  drives the program counter's Reset
PcBranch  out  1  drives the program counter's BranchAbs
PcTarget  out  L  drives the program counter's Target
Running  out  1  high in RUN
Done  out  1  high in DONE
CycleCount  out  CW  RUN cycles of the current or last program
Timeout  out  1  watchdog expiry flag

Behaviour:
- Reset: state=IDLE; start_q=0; sel_q=0; CycleCount=0; Timeout=0; Running=0; Done=0; PcReset=1 while Reset is high.
- Start edge = Start & ~start_q. start_q registers Start every cycle, including while Reset is high.
- States:
  - IDLE, on a Start edge with ProgSel<3: latch sel_q=ProgSel, go to LOAD. A ProgSel=3 edge is ignored and the state stays IDLE.
  - LOAD, one cycle: PcBranch=1, PcTarget=BASE[sel_q], CycleCount cleared to 0, Timeout cleared. Go to RUN, so PC=BASE at the start of RUN.
  - RUN: Running=1. CycleCount increments each cycle and saturates at all-ones.
    - HaltReq=1: PcBranch=1, PcTarget=CurPC (PC holds on the halt instruction); go to DONE.
    - else BranchReq=1: PcBranch=1, PcTarget=BranchTarget.
    - else: PcBranch=0, so the PC increments.
  - DONE: Done=1, PcBranch=1, PcTarget=CurPC (PC frozen), CycleCount frozen. A Start edge with ProgSel<3 latches sel_q and goes to LOAD. A ProgSel=3 edge is ignored.
- IDLE holds the PC the same way: PcBranch=1, PcTarget=CurPC.
- Default PcTarget when PcBranch=0 is CurPC.
- PcReset is high only while Reset is high; outside reset it is 0.
- Simultaneous events:
  - HaltReq and BranchReq together: halt wins.
  - Start edge in RUN or LOAD: ignored; no queuing.
  - Start held high: only one launch per rising edge.
- Reset mid-RUN: IDLE on the next edge; counters cleared; PC forced to 0 via PcReset.
- Latency: Start edge sampled at edge k → LOAD in cycle k+1 → first RUN fetch at BASE in cycle k+2. HaltReq sampled at edge n → Done=1 from cycle n+1.
- All outputs are Moore-style from state, except the RUN-state PcBranch/PcTarget, which combinationally follow HaltReq, BranchReq and BranchTarget.

Optional Feature:
WATCHDOG_EN
- With the macro defined: in RUN, if CycleCount reaches WDT_LIMIT-1 without HaltReq, go to DONE on the next edge with Timeout=1. Timeout holds until the next LOAD or Reset. A HaltReq in that same cycle takes precedence and Timeout stays 0.
- Without the macro: no watchdog logic; Timeout is tied to 0; RUN lasts until HaltReq.

Test Plan:
- Reset=1 for 2 cycles → PcReset=1, Done=0, Running=0, CycleCount=0. Release, 3 idle cycles → PcBranch=1, PcTarget=CurPC=0, PC stays 0.
- ProgSel=1, Start rising → LOAD with PcTarget=256; PC=256 two cycles after the edge, then 257, 258. Running=1.
- In RUN, BranchReq=1 with BranchTarget=300 for 1 cycle → PC=300 on the next edge, then 301. Both HaltReq and BranchReq asserted at PC=305 → PC stays 305, Done=1 the next cycle, CycleCount frozen.
- In DONE, Start held high for 5 cycles with ProgSel=2 → exactly one launch at PC=512. Start edge with ProgSel=3 in IDLE → stays IDLE.
- Reset asserted mid-RUN at PC=260 → next cycle IDLE, PC=0, CycleCount=0, Running=0.
- WATCHDOG_EN with WDT_LIMIT=8, no halt → DONE after 8 RUN cycles with Timeout=1, CycleCount=7. The next launch clears Timeout.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch controller in front of the program counter.
// It launches one of three stored programs on a rising edge of Start, passes
// decoder branch requests through while running, holds the PC on halt and
// reports Done.
//
// Optional feature macro: WATCHDOG_EN. When it is defined, a RUN that reaches
// WDT_LIMIT-1 cycles without a halt is forced to DONE with Timeout=1.
//
// Ports:
//   Clk          in   system clock, all state changes on the posedge
//   Reset        in   synchronous, active-high reset
//   Start        in   level; a rising edge launches a program
//   ProgSel      in   program select, sampled with the Start edge (3 = invalid)
//   CurPC        in   current program counter value
//   HaltReq      in   decoder: current instruction is halt
//   BranchReq    in   decoder: take branch this cycle
//   BranchTarget in   decoder: absolute branch target
//   PcReset      out  program counter Reset
//   PcBranch     out  program counter BranchAbs
//   PcTarget     out  program counter Target
//   Running      out  high in RUN
//   Done         out  high in DONE
//   CycleCount   out  RUN cycles of the current or last program
//   Timeout      out  watchdog expiry flag
module prog_sequencer #(
  parameter int L         = 10,
  parameter int BASE0     = 0,
  parameter int BASE1     = 256,
  parameter int BASE2     = 512,
  parameter int CW        = 16,
  parameter int WDT_LIMIT = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic [L-1:0]  CurPC,
  input  logic          HaltReq,
  input  logic          BranchReq,
  input  logic [L-1:0]  BranchTarget,
  output logic          PcReset,
  output logic          PcBranch,
  output logic [L-1:0]  PcTarget,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount,
  output logic          Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          start_q_r;
  logic [1:0]    sel_q_r;
  logic [CW-1:0] cycle_count_r;
  logic          start_edge_s;
  logic          launch_s;
  logic          wdt_fire_s;
  logic [L-1:0]  base_addr_s;

  // A launch needs a fresh rising edge and a valid program number.
  assign start_edge_s = Start & ~start_q_r;
  assign launch_s     = start_edge_s & (ProgSel != 2'd3);

  assign PcReset    = Reset;
  assign Running    = (state_r == RUN);
  assign Done       = (state_r == DONE);
  assign CycleCount = cycle_count_r;

`ifdef WATCHDOG_EN
  logic timeout_r;

  // A halt in the same cycle wins over the watchdog.
  assign wdt_fire_s = (state_r == RUN) && !HaltReq &&
                      (cycle_count_r == CW'(WDT_LIMIT - 1));
  assign Timeout    = timeout_r;

  // Watchdog flag: set on expiry, cleared by LOAD or Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timeout_r <= 1'b0;
    end else if (state_r == LOAD) begin
      timeout_r <= 1'b0;
    end else if (wdt_fire_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  assign wdt_fire_s = 1'b0;
  assign Timeout    = 1'b0;
`endif

  // Start address of the latched program.
  always_comb begin
    base_addr_s = L'(BASE0);
    case (sel_q_r)
      2'd0:    base_addr_s = L'(BASE0);
      2'd1:    base_addr_s = L'(BASE1);
      2'd2:    base_addr_s = L'(BASE2);
      default: base_addr_s = L'(BASE0);
    endcase
  end

  // Next state and PC control; outside RUN the PC is held or loaded.
  always_comb begin
    state_next_s = state_r;
    PcBranch     = 1'b1;
    PcTarget     = CurPC;
    case (state_r)
      IDLE, DONE: begin
        if (launch_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = state_r;
        end
      end
      LOAD: begin
        PcTarget     = base_addr_s;
        state_next_s = RUN;
      end
      RUN: begin
        if (HaltReq) begin
          // Re-load the halt address so the PC stays on it.
          PcBranch     = 1'b1;
          PcTarget     = CurPC;
          state_next_s = DONE;
        end else if (BranchReq) begin
          PcBranch     = 1'b1;
          PcTarget     = BranchTarget;
          state_next_s = wdt_fire_s ? DONE : RUN;
        end else begin
          PcBranch     = 1'b0;
          PcTarget     = CurPC;
          state_next_s = wdt_fire_s ? DONE : RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, Start edge detector, program latch and RUN cycle counter.
  always_ff @(posedge Clk) begin
    // The edge detector samples Start even during reset.
    start_q_r <= Start;
    if (Reset) begin
      state_r       <= IDLE;
      sel_q_r       <= 2'd0;
      cycle_count_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (((state_r == IDLE) || (state_r == DONE)) && launch_s) begin
        sel_q_r <= ProgSel;
      end else begin
        sel_q_r <= sel_q_r;
      end
      if (state_r == LOAD) begin
        cycle_count_r <= '0;
      end else if ((state_r == RUN) && !wdt_fire_s && (cycle_count_r != '1)) begin
        cycle_count_r <= cycle_count_r + CW'(1);
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer. A small program counter model (reset to
// 0, absolute load on PcBranch, otherwise +1) closes the loop through CurPC.
module tb_prog_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic [9:0]  CurPC;
  logic        HaltReq;
  logic        BranchReq;
  logic [9:0]  BranchTarget;
  logic        PcReset;
  logic        PcBranch;
  logic [9:0]  PcTarget;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCount;
  logic        Timeout;

  int n_cmp = 0;
  int n_err = 0;

  prog_sequencer #(.WDT_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .CurPC(CurPC),
    .HaltReq(HaltReq), .BranchReq(BranchReq), .BranchTarget(BranchTarget),
    .PcReset(PcReset), .PcBranch(PcBranch), .PcTarget(PcTarget),
    .Running(Running), .Done(Done), .CycleCount(CycleCount), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Program counter model driven by the sequencer outputs.
  always @(posedge Clk) begin
    if (PcReset)       CurPC <= 10'd0;
    else if (PcBranch) CurPC <= PcTarget;
    else               CurPC <= CurPC + 10'd1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0;
    HaltReq = 1'b0; BranchReq = 1'b0; BranchTarget = 10'd0;

    // Reset for two cycles
    step(); step();
    chk("rst_pcreset", 32'(PcReset), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_running", 32'(Running), 32'd0);
    chk("rst_cyc", 32'(CycleCount), 32'd0);
    chk("rst_timeout", 32'(Timeout), 32'd0);
    chk("rst_pc", 32'(CurPC), 32'd0);
    Reset = 1'b0; #1;
    chk("rel_pcreset", 32'(PcReset), 32'd0);

    // Idle holds PC
    step(); step(); step();
    chk("idle_branch", 32'(PcBranch), 32'd1);
    chk("idle_target", 32'(PcTarget), 32'd0);
    chk("idle_pc", 32'(CurPC), 32'd0);

    // Launch program 2 (ProgSel=1)
    ProgSel = 2'd1; Start = 1'b1;
    step();
    chk("load_branch", 32'(PcBranch), 32'd1);
    chk("load_target", 32'(PcTarget), 32'd256);
    chk("load_running", 32'(Running), 32'd0);
    step();
    chk("run1_pc", 32'(CurPC), 32'd256);
    chk("run1_running", 32'(Running), 32'd1);
    chk("run1_cyc", 32'(CycleCount), 32'd0);
    step();
    chk("run2_pc", 32'(CurPC), 32'd257);
    step();
    chk("run3_pc", 32'(CurPC), 32'd258);
    chk("run3_cyc", 32'(CycleCount), 32'd2);

    // Branch to 300 for one cycle
    BranchReq = 1'b1; BranchTarget = 10'd300; #1;
    chk("br_branch", 32'(PcBranch), 32'd1);
    chk("br_target", 32'(PcTarget), 32'd300);
    step();
    BranchReq = 1'b0; #1;
    chk("br_pc", 32'(CurPC), 32'd300);
    chk("nobr_branch", 32'(PcBranch), 32'd0);
    step();
    chk("br_next_pc", 32'(CurPC), 32'd301);
    step(); step(); step(); step();
    chk("pre_halt_pc", 32'(CurPC), 32'd305);
    chk("pre_halt_cyc", 32'(CycleCount), 32'd8);

    // Halt and branch together: halt wins
    HaltReq = 1'b1; BranchReq = 1'b1; BranchTarget = 10'd400; #1;
    chk("halt_target", 32'(PcTarget), 32'd305);
    step();
    HaltReq = 1'b0; BranchReq = 1'b0;
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_running", 32'(Running), 32'd0);
    chk("halt_pc", 32'(CurPC), 32'd305);
    chk("halt_cyc", 32'(CycleCount), 32'd9);
    step(); step();
    chk("frozen_pc", 32'(CurPC), 32'd305);
    chk("frozen_cyc", 32'(CycleCount), 32'd9);
    chk("no_retrig", 32'(Done), 32'd1);

    // Invalid program select in DONE is ignored
    Start = 1'b0; step();
    ProgSel = 2'd3; Start = 1'b1; step(); step();
    chk("done_sel3", 32'(Done), 32'd1);
    chk("done_sel3_pc", 32'(CurPC), 32'd305);

    // Start held high five cycles with ProgSel=2: one launch only
    Start = 1'b0; step();
    ProgSel = 2'd2; Start = 1'b1;
    step();
    chk("load2_target", 32'(PcTarget), 32'd512);
    step();
    chk("run_p3_pc", 32'(CurPC), 32'd512);
    step(); step(); step();
    chk("held_pc", 32'(CurPC), 32'd515);
    chk("held_running", 32'(Running), 32'd1);
    HaltReq = 1'b1; step(); HaltReq = 1'b0;
    step(); step();
    chk("held_done", 32'(Done), 32'd1);
    chk("held_done_pc", 32'(CurPC), 32'd515);

    // Reset mid-RUN at PC=260
    Start = 1'b0; step();
    ProgSel = 2'd1; Start = 1'b1; step(); step();
    Start = 1'b0;
    step(); step(); step(); step();
    chk("mid_pc", 32'(CurPC), 32'd260);
    Reset = 1'b1; #1;
    chk("mid_pcreset", 32'(PcReset), 32'd1);
    step();
    Reset = 1'b0;
    chk("mid_pc0", 32'(CurPC), 32'd0);
    chk("mid_cyc", 32'(CycleCount), 32'd0);
    chk("mid_running", 32'(Running), 32'd0);
    chk("mid_done", 32'(Done), 32'd0);

    // Invalid program select in IDLE is ignored
    step();
    ProgSel = 2'd3; Start = 1'b1; step(); step();
    chk("idle_sel3_run", 32'(Running), 32'd0);
    chk("idle_sel3_done", 32'(Done), 32'd0);
    chk("idle_sel3_pc", 32'(CurPC), 32'd0);

    // Launch program 1 (ProgSel=0) and let it run past the watchdog limit
    Start = 1'b0; step();
    ProgSel = 2'd0; Start = 1'b1; CurPC = 10'd0;
    step();
    chk("load0_target", 32'(PcTarget), 32'd0);
    step();
    chk("run0_running", 32'(Running), 32'd1);
    step(); step(); step(); step(); step(); step(); step();
    chk("wdt_pre_cyc", 32'(CycleCount), 32'd7);
    step();
`ifdef WATCHDOG_EN
    chk("wdt_done", 32'(Done), 32'd1);
    chk("wdt_timeout", 32'(Timeout), 32'd1);
    chk("wdt_cyc", 32'(CycleCount), 32'd7);
    Start = 1'b0; step();
    Start = 1'b1; step(); step();
    chk("wdt_clear", 32'(Timeout), 32'd0);
    chk("wdt_rerun", 32'(Running), 32'd1);
`else
    chk("nowdt_running", 32'(Running), 32'd1);
    chk("nowdt_timeout", 32'(Timeout), 32'd0);
    chk("nowdt_cyc", 32'(CycleCount), 32'd8);
    chk("nowdt_pc", 32'(CurPC), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
